mem_copy: RTL

Block-copy initiator for the 8-bit × 256-byte data memory. On a start pulse it copies `len` bytes from `src` to `dst` by driving the memory's address, write-data and write-enable lines and sampling its combinational read data. It sits between the CPU control path and the data memory port; the top level muxes its memory outputs onto the memory whenever `busy` is high.

---
 rtl/mem_copy.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mem_copy.sv
// rtl/mem_copy.sv - block-copy initiator for the data memory; define MEMCOPY_MEMMOVE_EN for overlap-safe (memmove) direction
module mem_copy #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_wr_en,
  input  logic [DW-1:0] mem_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [AW-1:0] ONE = AW'(1);

  state_t        state_q;
  logic [AW-1:0] src_q;
  logic [AW-1:0] dst_q;
  logic [AW-1:0] len_q;
  logic [AW-1:0] i_q;
  logic          desc_q;
  logic          desc_d;
  logic          busy_q;
  logic          done_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_din_q;
  logic          mem_wr_en_q;

  // Byte offset of the idx-th transfer: counts down from the end when descending.
  function automatic logic [AW-1:0] offset(input logic [AW-1:0] idx,
                                           input logic [AW-1:0] n,
                                           input logic          descending);
    return descending ? (n - ONE - idx) : idx;
  endfunction

  // Copy direction chosen from the live start inputs; descending only when dst lands inside the source tail.
`ifdef MEMCOPY_MEMMOVE_EN
  logic [AW-1:0] gap;
  always_comb begin
    gap    = dst - src;
    desc_d = (gap != '0) && (gap < len);
  end
`else
  always_comb begin
    desc_d = 1'b0;
  end
`endif

  // Copy FSM; every output is registered so nothing on start reaches the memory port combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      i_q         <= '0;
      desc_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      mem_wr_en_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            src_q   <= src;
            dst_q   <= dst;
            len_q   <= len;
            i_q     <= '0;
            desc_q  <= desc_d;
            busy_q  <= 1'b1;
            if (len == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= READ;
              mem_addr_q <= src + offset('0, len, desc_d);
            end
          end
        end
        READ: begin
          // mem_din_q doubles as the holding register for the byte just read.
          state_q     <= WRITE;
          mem_din_q   <= mem_dout;
          mem_addr_q  <= dst_q + offset(i_q, len_q, desc_q);
          mem_wr_en_q <= 1'b1;
        end
        WRITE: begin
          i_q         <= i_q + ONE;
          mem_din_q   <= '0;
          mem_wr_en_q <= 1'b0;
          if (i_q == len_q - ONE) begin
            state_q    <= DONE;
            done_q     <= 1'b1;
            mem_addr_q <= '0;
          end else begin
            state_q    <= READ;
            mem_addr_q <= src_q + offset(i_q + ONE, len_q, desc_q);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign mem_wr_en = mem_wr_en_q;

endmodule
